// File: rtl/spi_word_loader_if.sv
// Word output handshake between the SPI loader and the core's data/program registers.
// The master presents a word with its address and holds it until ready is seen.
interface spi_word_loader_if #(
   parameter int N = 8,
   parameter int A = 4
) ();
   logic [N-1:0] word_data;
   logic [A-1:0] word_addr;
   logic         word_valid;
   logic         word_ready;

   modport master (
      output word_data,
      output word_addr,
      output word_valid,
      input  word_ready
   );

   modport slave (
      input  word_data,
      input  word_addr,
      input  word_valid,
      output word_ready
   );
endinterface

// File: rtl/spi_word_loader.sv
// SPI mode-0 deserializer: packs MSB-first bits into N-bit words with an
// auto-incrementing address, presented through a valid/ready handshake.
module spi_word_loader #(
   parameter int N = 8,
   parameter int A = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               sclk,
   input  logic               mosi,
   input  logic               cs_n,
   spi_word_loader_if.master  wb,
   output logic               busy,
   output logic               overrun
);
   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t        st;
   logic          sclk_s1, sclk_s2, sclk_d;
   logic          mosi_s1, mosi_s2;
   logic          cs_s1, cs_s2, cs_d;
   logic          sclk_rise, cs_fall;
   logic [N-1:0]  shift_q;
   logic [N-1:0]  next_word;
   logic [CW-1:0] cnt;
   logic [A-1:0]  fa;

   assign sclk_rise = sclk_s2 & ~sclk_d;
   assign cs_fall   = ~cs_s2 & cs_d;
   assign next_word = {shift_q[N-2:0], mosi_s2};

   always_ff @(posedge clk) begin
      if (reset) begin
         st            <= IDLE;
         sclk_s1       <= 1'b0;
         sclk_s2       <= 1'b0;
         sclk_d        <= 1'b0;
         mosi_s1       <= 1'b0;
         mosi_s2       <= 1'b0;
         cs_s1         <= 1'b1;
         cs_s2         <= 1'b1;
         cs_d          <= 1'b1;
         shift_q       <= '0;
         cnt           <= '0;
         fa            <= '0;
         wb.word_data  <= '0;
         wb.word_addr  <= '0;
         wb.word_valid <= 1'b0;
         busy          <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         sclk_s1 <= sclk;
         sclk_s2 <= sclk_s1;
         sclk_d  <= sclk_s2;
         mosi_s1 <= mosi;
         mosi_s2 <= mosi_s1;
         cs_s1   <= cs_n;
         cs_s2   <= cs_s1;
         cs_d    <= cs_s2;

         if (wb.word_valid && wb.word_ready)
            wb.word_valid <= 1'b0;

         case (st)
            IDLE: begin
               if (cs_fall) begin
                  st      <= SHIFT;
                  busy    <= 1'b1;
                  cnt     <= '0;
                  shift_q <= '0;
                  fa      <= '0;
               end
            end
            SHIFT: begin
               // frame end beats a coincident sclk edge; partial word is lost
               if (cs_s2) begin
                  st   <= IDLE;
                  busy <= 1'b0;
               end else if (sclk_rise) begin
                  shift_q <= next_word;
                  if (cnt == LAST) begin
                     cnt <= '0;
                     if (!wb.word_valid || wb.word_ready) begin
                        wb.word_data  <= next_word;
                        wb.word_addr  <= fa;
                        wb.word_valid <= 1'b1;
                        fa            <= fa + 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            default: st <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_word_loader.sv
// Scoreboard bench for spi_word_loader: expected words are queued as they are
// sent over SPI and compared when the consumer accepts them.
module tb_spi_word_loader;
   localparam int N = 8;
   localparam int A = 4;

   typedef struct packed {
      logic [A-1:0] a;
      logic [N-1:0] d;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic sclk, mosi, cs_n;
   logic busy, overrun;

   spi_word_loader_if #(.N(N), .A(A)) bus ();

   spi_word_loader #(.N(N), .A(A)) dut (
      .clk     (clk),
      .reset   (reset),
      .sclk    (sclk),
      .mosi    (mosi),
      .cs_n    (cs_n),
      .wb      (bus),
      .busy    (busy),
      .overrun (overrun)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   exp_t q[$];
   exp_t mon_e;
   logic [A-1:0] exp_addr;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && bus.word_valid && bus.word_ready) begin
         if (q.size() == 0) begin
            chk("spurious_word", 32'd1, 32'd0);
         end else begin
            mon_e = q.pop_front();
            chk("word_data", 32'(bus.word_data), 32'(mon_e.d));
            chk("word_addr", 32'(bus.word_addr), 32'(mon_e.a));
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      mosi = b;
      wait_clk(4);
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
   endtask

   task automatic start_frame();
      cs_n = 1'b0;
      exp_addr = '0;
      wait_clk(4);
   endtask

   task automatic end_frame();
      wait_clk(4);
      cs_n = 1'b1;
      wait_clk(8);
   endtask

   task automatic expect_word(input logic [N-1:0] d);
      q.push_back('{a: exp_addr, d: d});
      exp_addr = exp_addr + 1'b1;
   endtask

   task automatic send_word(input logic [N-1:0] d, input bit accepted);
      if (accepted)
         expect_word(d);
      for (int i = N - 1; i >= 0; i--)
         send_bit(d[i]);
   endtask

   task automatic pulse_ready();
      @(posedge clk); #1;
      bus.word_ready = 1'b1;
      @(posedge clk); #1;
      bus.word_ready = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(q.size()), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [N-1:0] w;
      reset = 1'b1;
      sclk = 1'b0;
      mosi = 1'b0;
      cs_n = 1'b1;
      bus.word_ready = 1'b0;
      exp_addr = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data", 32'(bus.word_data), 32'd0);
      chk("rst_addr", 32'(bus.word_addr), 32'd0);
      chk("rst_valid", 32'(bus.word_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // 0xA5 held pending, latency from final sclk pin edge
      start_frame();
      chk("busy_in_frame", 32'(busy), 32'd1);
      w = 8'hA5;
      expect_word(w);
      for (int i = N - 1; i >= 1; i--)
         send_bit(w[i]);
      mosi = w[0];
      wait_clk(4);
      sclk = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("lat_valid_e2", 32'(bus.word_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("lat_valid_e3", 32'(bus.word_valid), 32'd1);
      wait_clk(4);
      sclk = 1'b0;
      end_frame();
      chk("busy_after", 32'(busy), 32'd0);
      chk("hold_valid", 32'(bus.word_valid), 32'd1);
      chk("hold_data", 32'(bus.word_data), 32'hA5);
      chk("hold_addr", 32'(bus.word_addr), 32'd0);
      pulse_ready();
      chk("valid_drop", 32'(bus.word_valid), 32'd0);
      drain("drain_a5");

      // three words, ready always high
      bus.word_ready = 1'b1;
      start_frame();
      send_word(8'h3C, 1'b1);
      send_word(8'hC3, 1'b1);
      send_word(8'hFF, 1'b1);
      end_frame();
      drain("drain_three");
      chk("no_overrun", 32'(overrun), 32'd0);

      // 17 words: address wraps to 0
      start_frame();
      for (int i = 0; i < 17; i++)
         send_word(N'($urandom_range(0, 255)), 1'b1);
      end_frame();
      drain("drain_wrap");

      // second word overruns a pending first
      bus.word_ready = 1'b0;
      start_frame();
      send_word(8'h11, 1'b1);
      send_word(8'h22, 1'b0);
      end_frame();
      chk("ovr_flag", 32'(overrun), 32'd1);
      chk("ovr_data", 32'(bus.word_data), 32'h11);
      chk("ovr_addr", 32'(bus.word_addr), 32'd0);
      chk("ovr_valid", 32'(bus.word_valid), 32'd1);
      pulse_ready();
      chk("ovr_valid_drop", 32'(bus.word_valid), 32'd0);
      chk("ovr_sticky", 32'(overrun), 32'd1);
      drain("drain_ovr");

      // partial word discarded, next frame restarts at address 0
      bus.word_ready = 1'b1;
      start_frame();
      for (int i = 0; i < 5; i++)
         send_bit(1'b1);
      end_frame();
      wait_clk(10);
      chk("partial_valid", 32'(bus.word_valid), 32'd0);
      start_frame();
      send_word(8'h5A, 1'b1);
      end_frame();
      drain("drain_5a");

      // reset mid-word with a pending word
      bus.word_ready = 1'b0;
      start_frame();
      send_word(8'h33, 1'b1);
      for (int i = 0; i < 3; i++)
         send_bit(1'b1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_data", 32'(bus.word_data), 32'd0);
      chk("mid_rst_addr", 32'(bus.word_addr), 32'd0);
      chk("mid_rst_valid", 32'(bus.word_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_overrun", 32'(overrun), 32'd0);
      q.delete();
      reset = 1'b0;
      cs_n = 1'b1;
      wait_clk(10);
      bus.word_ready = 1'b1;
      start_frame();
      send_word(8'h81, 1'b1);
      end_frame();
      drain("drain_81");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
